// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU definitions for the writeback arbiter and register scoreboard.
package regfile_wb_arbiter_pkg;

    localparam int CPU_DW   = 32;
    localparam int CPU_AW   = 5;
    localparam int REG_ZERO = 0;

    // Records which writeback port won the most recent completed handshake.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Outstanding-producer scoreboard: one busy bit per architectural register.
module reg_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int AW = CPU_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy;

    // The set is applied after the clear so an issue wins over a same-edge commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en && (clr_addr != AW'(REG_ZERO)))
                busy[clr_addr] <= 1'b0;
            if (set_en && (set_addr != AW'(REG_ZERO)))
                busy[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        busy1 = (rs1 == AW'(REG_ZERO)) ? 1'b0 : busy[rs1];
        busy2 = (rs2 == AW'(REG_ZERO)) ? 1'b0 : busy[rs2];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port round-robin writeback arbiter with a registered regfile write port
// and a busy scoreboard that is cleared by the committed write.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int AW = CPU_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_data,
    output logic          p0_ready,
    input  logic          p1_valid,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_data,
    output logic          p1_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          we
);

    port_e         last_grant;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // On contention the port that did not win last time is granted.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!rst) begin
            if (p0_valid && p1_valid) begin
                if (last_grant == PORT0)
                    p1_ready = 1'b1;
                else
                    p0_ready = 1'b1;
            end else begin
                p0_ready = p0_valid;
                p1_ready = p1_valid;
            end
        end
        sel_addr = p1_ready ? p1_addr : p0_addr;
        sel_data = p1_ready ? p1_data : p0_data;
    end

    // Reset leaves PORT1 as last winner so the first contended grant goes to p0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT1;
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
        end else begin
            we <= 1'b0;
            if (p0_ready || p1_ready) begin
                last_grant <= p1_ready ? PORT1 : PORT0;
                wa         <= sel_addr;
                wd         <= sel_data;
                we         <= (sel_addr != AW'(REG_ZERO));
            end
        end
    end

    reg_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid),
        .set_addr (iss_addr),
        .clr_en   (we),
        .clr_addr (wa),
        .rs1      (rs1),
        .rs2      (rs2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_valid, p1_valid;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_data, p1_data;
    logic          p0_ready, p1_ready;
    logic          iss_valid;
    logic [AW-1:0] iss_addr;
    logic [AW-1:0] rs1, rs2;
    logic          busy1, busy2;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_valid  (p0_valid),
        .p0_addr   (p0_addr),
        .p0_data   (p0_data),
        .p0_ready  (p0_ready),
        .p1_valid  (p1_valid),
        .p1_addr   (p1_addr),
        .p1_data   (p1_data),
        .p1_ready  (p1_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy1     (busy1),
        .busy2     (busy2),
        .wa        (wa),
        .wd        (wd),
        .we        (we)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic iv, input logic [AW-1:0] ia);
        p0_valid  = v0;
        p0_addr   = a0;
        p0_data   = d0;
        p1_valid  = v1;
        p1_addr   = a1;
        p1_data   = d1;
        iss_valid = iv;
        iss_addr  = ia;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d0, d1;
        rst = 1'b1;
        rs1 = '0;
        rs2 = '0;
        idle();
        tick();
        tick();

        // Readys suppressed while reset is high even with both ports requesting.
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, '0);
        checkOutput("rst_p0_ready", 32'(p0_ready), 32'd0);
        checkOutput("rst_p1_ready", 32'(p1_ready), 32'd0);
        tick();
        idle();
        rst = 1'b0;
        #1;
        checkOutput("reset_we", 32'(we), 32'd0);
        checkOutput("reset_wa", 32'(wa), 32'd0);
        checkOutput("reset_wd", wd, 32'd0);
        rs1 = 5'd3;
        #1;
        checkOutput("reset_busy3", 32'(busy1), 32'd0);

        // Single p0 request.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
        checkOutput("single_p0_ready", 32'(p0_ready), 32'd1);
        checkOutput("single_p1_ready", 32'(p1_ready), 32'd0);
        tick();
        idle();
        checkOutput("single_we", 32'(we), 32'd1);
        checkOutput("single_wa", 32'(wa), 32'd5);
        checkOutput("single_wd", wd, 32'hDEADBEEF);
        tick();
        checkOutput("single_we_drop", 32'(we), 32'd0);

        // Contention after reset alternates p0, p1, p0, p1.
        doReset();
        for (int i = 0; i < 4; i++) begin
            d0 = 32'hA000_0000 + 32'(i);
            d1 = 32'hB000_0000 + 32'(i);
            applyStimulus(1'b1, 5'd1, d0, 1'b1, 5'd2, d1, 1'b0, '0);
            checkOutput($sformatf("rr%0d_p0_ready", i), 32'(p0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr%0d_p1_ready", i), 32'(p1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            checkOutput($sformatf("rr%0d_we", i), 32'(we), 32'd1);
            checkOutput($sformatf("rr%0d_wa", i), 32'(wa), (i % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("rr%0d_wd", i), wd, (i % 2 == 0) ? d0 : d1);
        end
        idle();
        tick();

        // Issue to r7, then a p1 writeback clears it at the commit edge.
        rs1 = 5'd7;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        checkOutput("busy7_before_issue", 32'(busy1), 32'd0);
        tick();
        idle();
        checkOutput("busy7_set", 32'(busy1), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_7777, 1'b0, '0);
        checkOutput("wb7_p1_ready", 32'(p1_ready), 32'd1);
        tick();
        idle();
        checkOutput("wb7_we", 32'(we), 32'd1);
        checkOutput("wb7_wa", 32'(wa), 32'd7);
        checkOutput("busy7_during_commit", 32'(busy1), 32'd1);
        tick();
        checkOutput("busy7_cleared", 32'(busy1), 32'd0);

        // Same-edge issue and commit to r9: set wins.
        rs2 = 5'd9;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h9999, 1'b0, '0, '0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
        checkOutput("r9_commit_we", 32'(we), 32'd1);
        tick();
        idle();
        checkOutput("busy9_set_wins", 32'(busy2), 32'd1);
        applyStimulus(1'b1, 5'd9, 32'h9999, 1'b0, '0, '0, 1'b0, '0);
        tick();
        idle();
        tick();
        checkOutput("busy9_cleared", 32'(busy2), 32'd0);

        // Address zero is accepted but never written, and r0 never reads busy.
        rs1 = 5'd0;
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
        checkOutput("r0_p1_ready", 32'(p1_ready), 32'd1);
        tick();
        idle();
        checkOutput("r0_we", 32'(we), 32'd0);
        checkOutput("r0_busy", 32'(busy1), 32'd0);

        // Writing a non-busy register leaves other busy bits alone.
        rs1 = 5'd3;
        rs2 = 5'd4;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h4444, 1'b0, '0, '0, 1'b0, '0);
        tick();
        idle();
        checkOutput("r4_we", 32'(we), 32'd1);
        tick();
        checkOutput("busy3_kept", 32'(busy1), 32'd1);
        checkOutput("busy4_idle", 32'(busy2), 32'd0);

        // Reset with both ports requesting and r3 busy.
        rst = 1'b1;
        applyStimulus(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB, 1'b0, '0);
        checkOutput("rst2_p0_ready", 32'(p0_ready), 32'd0);
        checkOutput("rst2_p1_ready", 32'(p1_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst2_we", 32'(we), 32'd0);
        checkOutput("rst2_busy3", 32'(busy1), 32'd0);
        checkOutput("rst2_first_p0", 32'(p0_ready), 32'd1);
        checkOutput("rst2_first_p1", 32'(p1_ready), 32'd0);
        tick();
        idle();
        checkOutput("rst2_wa", 32'(wa), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
